shift_reg_burst: RTL



---
 rtl/shift_reg_pkg.sv | 22 ++
 rtl/shift_step.sv | 46 ++++
 rtl/shift_reg_burst.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_burst block:
// operation codes and controller states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'b000,
    SHR   = 3'b001,
    SHL   = 3'b010,
    ROR   = 3'b011,
    ROL   = 3'b100,
    ASR   = 3'b101,
    CLEAR = 3'b110,
    NOP   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shifter: one step of
// the selected shift mode plus the bit pushed out.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    unique case (op)
      SHR: begin
        next_q  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      SHL: begin
        next_q  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      ASR: begin
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_burst.sv
// Universal shift register with a command handshake;
// multi-bit shifts are sequenced one bit per clock.
module shift_reg_burst
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nx;
  op_e              op_q, op_nx;
  logic [CNT_W-1:0] remaining, rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic             so_nx;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  op_e              cmd_op_e;

  assign cmd_op_e = op_e'(cmd_op);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op       (op_q),
    .q        (q),
    .serial_in(serial_in),
    .next_q   (step_q),
    .out_bit  (step_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '0;
      serial_out <= 1'b0;
      remaining  <= '0;
      op_q       <= NOP;
    end else begin
      q          <= q_nx;
      serial_out <= so_nx;
      remaining  <= rem_nx;
      op_q       <= op_nx;
    end
  end

  always_comb begin
    state_nx = state;
    q_nx     = q;
    so_nx    = serial_out;
    rem_nx   = remaining;
    op_nx    = op_q;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op_e)
            LOAD: begin
              q_nx     = cmd_data;
              state_nx = DONE;
            end
            CLEAR: begin
              q_nx     = '0;
              state_nx = DONE;
            end
            NOP: begin
              state_nx = DONE;
            end
            SHR, SHL, ROR, ROL, ASR: begin
              if (cmd_amount == '0) begin
                state_nx = DONE;
              end else begin
                op_nx    = cmd_op_e;
                rem_nx   = cmd_amount;
                state_nx = RUN;
              end
            end
            default: state_nx = DONE;
          endcase
        end
      end
      RUN: begin
        q_nx   = step_q;
        so_nx  = step_bit;
        rem_nx = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
